// File: rtl/key_req_capture_pkg.sv
// Shared constants, FSM state type and the request priority picker for the key front end.
package key_pkg;

    localparam int unsigned NUM_KEYS = 4;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_e;

    // Highest-index set bit wins; returns its one-hot, or zero when nothing is set.
    function automatic logic [NUM_KEYS-1:0] prio_onehot(input logic [NUM_KEYS-1:0] req);
        logic [NUM_KEYS-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (req[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/key_req_capture_if.sv
// Request handshake towards the 4-to-2 encoder: one-hot code, valid strobe, ready.
interface key_req_capture_if;
    import key_pkg::*;

    logic [NUM_KEYS-1:0] code_i;
    logic                code_en;
    logic                code_ready;

    modport master (
        output code_i,
        output code_en,
        input  code_ready
    );

    modport slave (
        input  code_i,
        input  code_en,
        output code_ready
    );

endinterface

// File: rtl/key_req_capture_debounce.sv
// One key line: two-flop synchroniser, consecutive-difference debounce and press pulse.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_stable,
    output logic o_press
);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_flip;

    assign w_diff = r_s2 ^ r_stable;
    assign w_flip = w_diff && (r_cnt == CNT_W'(DEB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_key;
            r_s2 <= r_s1;
            // Any agreement with the stable level restarts the run, dropping short glitches.
            if (!w_diff || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_flip) begin
                r_stable <= ~r_stable;
            end
            r_press <= w_flip & ~r_stable;
        end
    end

    assign o_stable = r_stable;
    assign o_press  = r_press;

endmodule

// File: rtl/key_req_capture.sv
// Debounced key presses collected into a pending bitmap and offered one at a time as one-hot.
module key_req_capture
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] i_key_in,
    output logic [NUM_KEYS-1:0] o_key_stable,
    output logic                o_key_drop,
    key_req_capture_if.master   code_if
);

    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_issue;
    logic [NUM_KEYS-1:0] w_pend_d;
    logic [NUM_KEYS-1:0] w_code_d;
    logic                w_en_d;
    logic                w_drop_d;
    state_e              w_state_d;

    logic [NUM_KEYS-1:0] r_pend;
    logic [NUM_KEYS-1:0] r_code;
    logic                r_en;
    logic                r_drop;
    state_e              r_state;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_key    (i_key_in[k]),
            .o_stable (o_key_stable[k]),
            .o_press  (w_press[k])
        );
    end

    always_comb begin
        w_state_d = r_state;
        w_code_d  = r_code;
        w_en_d    = r_en;
        w_issue   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_pend != '0) begin
                    w_issue   = prio_onehot(r_pend);
                    w_code_d  = w_issue;
                    w_en_d    = 1'b1;
                    w_state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (code_if.code_ready) begin
                    w_code_d  = '0;
                    w_en_d    = 1'b0;
                    w_state_d = ST_IDLE;
                end
            end
        endcase
        // A press landing on the edge its key is issued survives as a fresh request.
        w_pend_d = (r_pend & ~w_issue) | w_press;
        w_drop_d = |(w_press & r_pend & ~w_issue);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_code  <= '0;
            r_en    <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_pend  <= w_pend_d;
            r_code  <= w_code_d;
            r_en    <= w_en_d;
            r_drop  <= w_drop_d;
        end
    end

    assign code_if.code_i  = r_code;
    assign code_if.code_en = r_en;
    assign o_key_drop      = r_drop;

endmodule

// File: tb/tb_key_req_capture.sv
// Randomised and directed bench for key_req_capture against a sample-history reference model.
module tb_key_req_capture;

    localparam int unsigned DEB = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_in;
    logic [3:0] key_stable;
    logic       key_drop;

    key_req_capture_if u_if ();

    key_req_capture #(
        .DEB_CYCLES (DEB),
        .CNT_W      (20)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_key_in     (key_in),
        .o_key_stable (key_stable),
        .o_key_drop   (key_drop),
        .code_if      (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a key's stable level flips once its last DEB synchronised samples
    // all disagree with it; requests are a set of pending keys plus the one on offer.
    logic [3:0]     m_s1, m_s2, m_stable, m_press, m_pend;
    logic [DEB-1:0] m_hist [4];
    logic           m_drop;
    int             m_offer;

    task automatic model_step(input logic [3:0] k, input logic rdy, input logic rn);
        logic [3:0] samp, flip, iss;
        int         hi;
        if (!rn) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_press = '0; m_pend = '0;
            m_drop = 1'b0; m_offer = -1;
            for (int i = 0; i < 4; i++) m_hist[i] = '0;
            return;
        end
        samp = m_s2;
        m_s2 = m_s1;
        m_s1 = k;
        flip = '0;
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = {m_hist[i][DEB-2:0], samp[i]};
            if (m_hist[i] == {DEB{~m_stable[i]}}) flip[i] = 1'b1;
        end
        iss = '0;
        hi  = -1;
        if (m_offer < 0) begin
            for (int i = 3; i >= 0; i--) begin
                if (m_pend[i]) begin
                    hi = i;
                    break;
                end
            end
            if (hi >= 0) iss[hi] = 1'b1;
        end
        m_drop = |(m_press & m_pend & ~iss);
        m_pend = (m_pend & ~iss) | m_press;
        if (m_offer >= 0) begin
            if (rdy) m_offer = -1;
        end else if (hi >= 0) begin
            m_offer = hi;
        end
        m_press  = flip & ~m_stable;
        m_stable = m_stable ^ flip;
    endtask

    function automatic logic [3:0] m_code();
        logic [3:0] c;
        c = '0;
        if (m_offer >= 0) c[m_offer] = 1'b1;
        return c;
    endfunction

    task automatic cycle(input logic [3:0] k, input logic rdy, input logic rn);
        key_in          = k;
        u_if.code_ready = rdy;
        rst_n           = rn;
        @(posedge clk);
        model_step(k, rdy, rn);
        #1;
        check("code_i", 32'(u_if.code_i), 32'(m_code()));
        check("code_en", 32'(u_if.code_en), 32'(m_offer >= 0));
        check("key_stable", 32'(key_stable), 32'(m_stable));
        check("key_drop", 32'(key_drop), 32'(m_drop));
    endtask

    initial begin
        int         first;
        int         drops;
        int         offers;
        logic       seen_en;
        logic       seen_st;
        logic       prev_en;
        logic [3:0] prev_code;
        logic [3:0] lvl;
        int         left [4];
        logic       rdy, rn;

        key_in          = '0;
        u_if.code_ready = 1'b0;
        rst_n           = 1'b0;
        #2;

        // Reset state
        cycle(4'b0000, 1'b0, 1'b0);
        check("reset_en", 32'(u_if.code_en), 32'd0);
        check("reset_code", 32'(u_if.code_i), 32'd0);
        check("reset_stable", 32'(key_stable), 32'd0);

        // Clean press: first sample at edge 0, offered after edge DEB+3 for one cycle
        first  = -1;
        offers = 0;
        for (int e = 0; e < 20; e++) begin
            cycle(4'b0001, 1'b1, 1'b1);
            if (u_if.code_en) begin
                offers++;
                if (first < 0) first = e;
            end
        end
        check("clean_latency", 32'(first), 32'(DEB + 3));
        check("clean_one_cycle", 32'(offers), 32'd1);
        check("clean_stable0", 32'(key_stable[0]), 32'd1);
        for (int e = 0; e < 10; e++) cycle(4'b0000, 1'b1, 1'b1);

        // Bounce rejection on key 2
        cycle(4'b0000, 1'b1, 1'b0);
        seen_en = 1'b0;
        seen_st = 1'b0;
        for (int e = 0; e < 30; e++) begin
            cycle((e < 20 && ((e / 2) % 2) == 1) ? 4'b0100 : 4'b0000, 1'b1, 1'b1);
            seen_en |= u_if.code_en;
            seen_st |= key_stable[2];
        end
        check("bounce_no_en", 32'(seen_en), 32'd0);
        check("bounce_no_stable", 32'(seen_st), 32'd0);

        // Priority and hold: keys 1 and 3 together, consumer stalls
        cycle(4'b0000, 1'b0, 1'b0);
        for (int e = 0; e < 20 && !u_if.code_en; e++) cycle(4'b1010, 1'b0, 1'b1);
        check("prio_offer_en", 32'(u_if.code_en), 32'd1);
        for (int e = 0; e < 10; e++) cycle(4'b1010, 1'b0, 1'b1);
        check("prio_hold_code", 32'(u_if.code_i), 32'h8);
        cycle(4'b1010, 1'b1, 1'b1);
        check("prio_bubble", 32'(u_if.code_en), 32'd0);
        cycle(4'b1010, 1'b0, 1'b1);
        check("prio_next_code", 32'(u_if.code_i), 32'h2);
        for (int e = 0; e < 4; e++) cycle(4'b0000, 1'b1, 1'b1);

        // Merge and drop: key 0 pressed twice while key 3 sits in HOLD
        cycle(4'b0000, 1'b0, 1'b0);
        for (int e = 0; e < 20 && !u_if.code_en; e++) cycle(4'b1000, 1'b0, 1'b1);
        drops = 0;
        for (int e = 0; e < 30; e++) begin
            cycle((e >= 10 && e < 20) ? 4'b1000 : 4'b1001, 1'b0, 1'b1);
            drops += int'(key_drop);
        end
        check("merge_drops", 32'(drops), 32'd1);
        offers  = 0;
        prev_en = u_if.code_en;
        for (int e = 0; e < 12; e++) begin
            cycle(4'b1001, 1'b1, 1'b1);
            if (u_if.code_en && !prev_en && u_if.code_i == 4'b0001) offers++;
            prev_en = u_if.code_en;
        end
        check("merge_k0_offers", 32'(offers), 32'd1);

        // Reset during HOLD with key 2 still down
        cycle(4'b0000, 1'b0, 1'b0);
        for (int e = 0; e < 20 && !u_if.code_en; e++) cycle(4'b0100, 1'b0, 1'b1);
        cycle(4'b0100, 1'b0, 1'b1);
        cycle(4'b0100, 1'b0, 1'b0);
        check("rst_mid_en", 32'(u_if.code_en), 32'd0);
        check("rst_mid_code", 32'(u_if.code_i), 32'd0);
        first = -1;
        for (int e = 1; e < 20 && first < 0; e++) begin
            cycle(4'b0100, 1'b0, 1'b1);
            if (u_if.code_en) first = e;
        end
        // Release edge is call 1, so the offer follows DEB+3 edges later
        check("rst_reoffer_latency", 32'(first), 32'(DEB + 4));
        check("rst_reoffer_code", 32'(u_if.code_i), 32'h4);

        // Randomised bouncing keys with a random consumer
        cycle(4'b0000, 1'b0, 1'b0);
        lvl = '0;
        for (int i = 0; i < 4; i++) left[i] = 1;
        prev_en   = u_if.code_en;
        prev_code = u_if.code_i;
        for (int e = 0; e < 2000; e++) begin
            for (int i = 0; i < 4; i++) begin
                left[i]--;
                if (left[i] <= 0) begin
                    lvl[i]  = ~lvl[i];
                    left[i] = int'($urandom_range(1, 9));
                end
            end
            rdy = 1'($urandom_range(0, 1));
            rn  = ($urandom_range(0, 499) != 0);
            cycle(lvl, rdy, rn);
            if (u_if.code_en) begin
                check("inv_onehot", 32'($onehot(u_if.code_i)), 32'd1);
            end else begin
                check("inv_zero", 32'(u_if.code_i), 32'd0);
            end
            if (rn && prev_en && !rdy) begin
                check("inv_hold", 32'(u_if.code_i), 32'(prev_code));
            end
            prev_en   = u_if.code_en;
            prev_code = u_if.code_i;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
